// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative RV32M multiply/divide unit. Shift-add multiply and
//                restoring divide over operand magnitudes, sign fix-up and
//                special-case selection in a final FIX step. Fixed latency.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  input  logic [4:0]  i_rd_in,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_result,
  output logic [4:0]  o_rd_out,
  output logic        o_we
);

  localparam logic [2:0] c_MUL    = 3'b000;
  localparam logic [2:0] c_MULH   = 3'b001;
  localparam logic [2:0] c_MULHSU = 3'b010;
  localparam logic [2:0] c_MULHU  = 3'b011;
  localparam logic [2:0] c_DIV    = 3'b100;
  localparam logic [2:0] c_DIVU   = 3'b101;
  localparam logic [2:0] c_REM    = 3'b110;
  localparam logic [2:0] c_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [2:0]  r_f3;
  logic [4:0]  r_rd;
  logic [31:0] r_hi;      // product high half / partial remainder
  logic [31:0] r_lo;      // multiplier bits + product low half / quotient
  logic [31:0] r_b;       // multiplicand magnitude / divisor magnitude
  logic [31:0] r_a;       // original dividend, returned on REM by zero
  logic        r_negq;    // negate product or quotient
  logic        r_negr;    // negate remainder
  logic        r_dz;      // divisor was zero
  logic        r_ovf;     // signed overflow 0x80000000 / -1
  logic        r_busy;
  logic        r_done;
  logic        r_we;
  logic [31:0] r_result;
  logic [4:0]  r_rd_out;

  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_sum;
  logic [32:0] w_trial;
  logic [33:0] w_diff;
  logic        w_ge;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_final;

  // Operand signedness decode and magnitude extraction at accept time
  always_comb begin
    w_a_signed = (i_funct3 == c_MULH) || (i_funct3 == c_MULHSU) ||
                 (i_funct3 == c_DIV)  || (i_funct3 == c_REM);
    w_b_signed = (i_funct3 == c_MULH) || (i_funct3 == c_DIV) ||
                 (i_funct3 == c_REM);
    w_a_neg    = w_a_signed && i_op_a[31];
    w_b_neg    = w_b_signed && i_op_b[31];
    w_a_mag    = w_a_neg ? (32'd0 - i_op_a) : i_op_a;
    w_b_mag    = w_b_neg ? (32'd0 - i_op_b) : i_op_b;
  end

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : 33'd0);
    w_trial = {r_hi, r_lo[31]};
    w_diff  = {1'b0, w_trial} - {2'b00, r_b};
    w_ge    = ~w_diff[33];
  end

  // Sign correction and special-case result selection for the FIX step
  always_comb begin
    w_prod  = r_negq ? (64'd0 - {r_hi, r_lo}) : {r_hi, r_lo};
    w_quo   = r_negq ? (32'd0 - r_lo) : r_lo;
    w_rem   = r_negr ? (32'd0 - r_hi) : r_hi;
    w_final = 32'd0;
    case (r_f3)
      c_MUL:                     w_final = w_prod[31:0];
      c_MULH, c_MULHSU, c_MULHU: w_final = w_prod[63:32];
      c_DIV, c_DIVU: begin
        if (r_dz)       w_final = 32'hFFFF_FFFF;
        else if (r_ovf) w_final = 32'h8000_0000;
        else            w_final = w_quo;
      end
      default: begin
        if (r_dz)       w_final = r_a;
        else if (r_ovf) w_final = 32'd0;
        else            w_final = w_rem;
      end
    endcase
  end

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_f3     <= 3'd0;
      r_rd     <= 5'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_b      <= 32'd0;
      r_a      <= 32'd0;
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_we     <= 1'b0;
      r_result <= 32'd0;
      r_rd_out <= 5'd0;
    end else begin
      r_done <= 1'b0;
      r_we   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_CALC;
            r_busy  <= 1'b1;
            r_cnt   <= 5'd0;
            r_f3    <= i_funct3;
            r_rd    <= i_rd_in;
            r_a     <= i_op_a;
            r_hi    <= 32'd0;
            r_negr  <= w_a_neg;
            r_negq  <= (i_funct3 == c_MUL || i_funct3 == c_MULHU) ?
                       1'b0 : (w_a_neg ^ w_b_neg);
            r_dz    <= (i_op_b == 32'd0);
            r_ovf   <= (i_funct3 == c_DIV || i_funct3 == c_REM) &&
                       (i_op_a == 32'h8000_0000) && (i_op_b == 32'hFFFF_FFFF);
            if (i_funct3[2]) begin
              // divide: dividend shifts out of r_lo, quotient shifts in
              r_lo <= w_a_mag;
              r_b  <= w_b_mag;
            end else begin
              // multiply: multiplier in r_lo, multiplicand added into r_hi
              r_lo <= w_b_mag;
              r_b  <= w_a_mag;
            end
          end
        end
        S_CALC: begin
          if (r_f3[2]) begin
            r_hi <= w_ge ? w_diff[31:0] : w_trial[31:0];
            r_lo <= {r_lo[30:0], w_ge};
          end else begin
            r_hi <= w_sum[32:1];
            r_lo <= {w_sum[0], r_lo[31:1]};
          end
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_FIX;
        end
        S_FIX: begin
          r_state  <= S_DONE;
          r_result <= w_final;
          r_rd_out <= r_rd;
          r_done   <= 1'b1;
          r_we     <= (r_rd != 5'd0);
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_we     = r_we;
  assign o_result = r_result;
  assign o_rd_out = r_rd_out;

endmodule
`default_nettype wire
